// File: rtl/counter_pkg.sv
// Shared width, type and reset constant for the binary counter family.
package counter_pkg;

    localparam int COUNTER_W = 4;

    typedef logic [COUNTER_W-1:0] count_t;

    localparam count_t COUNT_RESET = '0;

endpackage : counter_pkg

// File: rtl/ripple_incrementer.sv
// Structural +cin incrementer: a ripple chain of half-adder cells with an explicit carry path.
module ripple_incrementer #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_half_adder
        assign sum[i]     = a[i] ^ carry[i];
        assign carry[i+1] = a[i] & carry[i];
    end

    assign cout = carry[WIDTH];

endmodule : ripple_incrementer

// File: rtl/binary_up_counter_4bit.sv
// Free-running binary up counter with synchronous active-high reset; wraps modulo 2^WIDTH.
module binary_up_counter_4bit
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_inc;
    logic             unused_cout;

    // The MSB carry-out is the wrap indication and is deliberately dropped.
    ripple_incrementer #(
        .WIDTH (WIDTH)
    ) u_inc (
        .a    (count_q),
        .cin  (1'b1),
        .sum  (count_inc),
        .cout (unused_cout)
    );

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= WIDTH'(COUNT_RESET);
        end else begin
            count_q <= count_inc;
        end
    end

    assign count = count_q;

endmodule : binary_up_counter_4bit

// File: tb/tb_binary_up_counter_4bit.sv
// Self-checking bench: directed and random reset patterns against an edge-counting model.
module tb_binary_up_counter_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;

    // Reference model: number of rising edges seen with rst low since the last reset edge.
    int  edges_since_reset = 0;
    bit  model_valid       = 1'b0;

    binary_up_counter_4bit #(
        .WIDTH (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model_count();
        return 4'(edges_since_reset % 16);
    endfunction

    task automatic check(input string tag, input logic [3:0] expected);
        checks++;
        assert (count === expected)
        else begin
            errors++;
            $error("FAIL %s: count=%b expected=%b", tag, count, expected);
        end
    endtask

    // Drive rst, take one rising edge, update the model, then compare at the falling edge.
    task automatic tick(input logic r, input string tag);
        rst = r;
        @(posedge clk);
        if (r) begin
            edges_since_reset = 0;
            model_valid       = 1'b1;
        end else begin
            edges_since_reset++;
        end
        @(negedge clk);
        if (model_valid) check(tag, model_count());
    endtask

    initial begin
        rst = 1'b1;

        // Reset from unknown, held for two edges.
        tick(1'b1, "reset_edge1");
        tick(1'b1, "reset_edge2");
        check("reset_state", 4'b0000);

        // Release: 1, 2, 3.
        tick(1'b0, "release_1");
        check("count_1", 4'b0001);
        tick(1'b0, "release_2");
        check("count_2", 4'b0010);
        tick(1'b0, "release_3");
        check("count_3", 4'b0011);

        // Rollover: 13 more edges from 3, with 15 on the twelfth.
        for (int i = 0; i < 12; i++) tick(1'b0, "to_rollover");
        check("before_wrap", 4'b1111);
        tick(1'b0, "wrap");
        check("after_wrap", 4'b0000);

        // Mid-count reset at 9.
        for (int i = 0; i < 9; i++) tick(1'b0, "to_nine");
        check("at_nine", 4'd9);
        tick(1'b1, "mid_reset");
        check("mid_reset_zero", 4'b0000);
        tick(1'b0, "mid_release");
        check("mid_release_one", 4'b0001);

        // Reset held at the wrap point for three edges.
        for (int i = 0; i < 14; i++) tick(1'b0, "to_fifteen");
        check("at_fifteen", 4'b1111);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, "held_reset");
            check("held_reset_zero", 4'b0000);
        end

        // A reset pulse between rising edges must be ignored.
        tick(1'b0, "pre_glitch");
        rst = 1'b1;
        #2 rst = 1'b0;
        tick(1'b0, "post_glitch");
        check("glitch_ignored", 4'd2);

        // Long run: 100 edges after a fresh reset.
        tick(1'b1, "long_reset");
        for (int i = 0; i < 100; i++) tick(1'b0, "long_run");
        check("long_run_end", 4'd4);

        // Random reset pattern; roughly one edge in eight asserts reset.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 7) == 0), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_binary_up_counter_4bit
